uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled by a programmable bit period, 8/9 data bits sent MSB first,
// 1 or 2 stop bits, with framing-error reporting and break (stuck-low) suppression.
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_in,
    input  logic [15:0] br_div,
    input  logic        word,
    input  logic        stop,
    output logic [8:0]  data,
    output logic        valid,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [15:0] br_q, br_d;
    logic        word_q, word_d;
    logic        stop2_q, stop2_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        stop_idx_q, stop_idx_d;
    logic        err_q, err_d;
    logic [8:0]  sh_q, sh_d;
    logic [8:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    logic [15:0] half;
    logic [3:0]  last_bit;
    logic        stop_err;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign half     = br_q >> 1;
    assign last_bit = word_q ? 4'd8 : 4'd7;
    assign stop_err = err_q | ~rxs;

    // Synchronizer resets to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            br_q       <= 16'd0;
            word_q     <= 1'b0;
            stop2_q    <= 1'b0;
            cnt_q      <= 16'd0;
            bit_q      <= 4'd0;
            stop_idx_q <= 1'b0;
            err_q      <= 1'b0;
            sh_q       <= 9'd0;
            data_q     <= 9'd0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            br_q       <= br_d;
            word_q     <= word_d;
            stop2_q    <= stop2_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_idx_q <= stop_idx_d;
            err_q      <= err_d;
            sh_q       <= sh_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        br_d       = br_q;
        word_d     = word_q;
        stop2_d    = stop2_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_idx_d = stop_idx_q;
        err_d      = err_q;
        sh_d       = sh_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = ferr_q;

        unique case (state_q)
            StIdle: begin
                if (rxs) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = StStart;
                    br_d       = br_div;
                    word_d     = word;
                    stop2_d    = stop;
                    cnt_d      = 16'd1;
                    bit_d      = 4'd0;
                    stop_idx_d = 1'b0;
                    err_d      = 1'b0;
                    sh_d       = 9'd0;
                end
            end
            StStart: begin
                if (cnt_q == half) begin
                    cnt_d   = 16'd1;
                    state_d = rxs ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (cnt_q == br_q) begin
                    cnt_d = 16'd1;
                    sh_d  = {sh_q[7:0], rxs};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == last_bit) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == br_q) begin
                    cnt_d = 16'd1;
                    err_d = stop_err;
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b1;
                        data_d  = word_q ? sh_q : {1'b0, sh_q[7:0]};
                        ferr_d  = stop_err;
                        // A bad frame disarms so a held break cannot retrigger.
                        if (stop_err) begin
                            armed_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: records the line per cycle, predicts every output per cycle
// from the sampling-time rules, and adds directed checks for the named scenarios.
module tb_uart_rx;

    localparam int S    = 2;
    localparam int MAXC = 16384;
    localparam int L    = S + 8 + 9 * 16 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_in = 1'b1;
    logic [15:0] br_div = 16'd16;
    logic        word = 1'b0;
    logic        stop = 1'b0;
    logic [8:0]  data;
    logic        valid;
    logic        frame_err;
    logic        busy;

    uart_rx #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .br_div    (br_div),
        .word      (word),
        .stop      (stop),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle record of stimulus and observed outputs.
    bit          line_a [MAXC];
    bit          rst_a  [MAXC];
    bit   [15:0] br_a   [MAXC];
    bit          word_a [MAXC];
    bit          stop_a [MAXC];
    logic        ov_a   [MAXC];
    logic        ob_a   [MAXC];
    logic        oe_a   [MAXC];
    logic [8:0]  od_a   [MAXC];

    // Model predictions.
    bit          eb_a   [MAXC];
    bit          ev_a   [MAXC];
    bit   [8:0]  ed_a   [MAXC];
    bit          ee_a   [MAXC];

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            line_a[cyc] = rx_in;
            rst_a[cyc]  = rst;
            br_a[cyc]   = br_div;
            word_a[cyc] = word;
            stop_a[cyc] = stop;
            ov_a[cyc]   = valid;
            ob_a[cyc]   = busy;
            oe_a[cyc]   = frame_err;
            od_a[cyc]   = data;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) tick();
    endtask

    // Serial transmitter; optionally scrambles the config mid-frame and restores it at stop.
    task automatic send_frame(input logic [8:0] d, input int nb, input int ns, input int per,
                              input bit stop_val, input int chg);
        logic [15:0] br0;
        logic        w0;
        logic        s0;
        br0 = br_div;
        w0  = word;
        s0  = stop;
        rx_in = 1'b0;
        repeat (per) tick();
        for (int k = 0; k < nb; k++) begin
            if (k == chg) begin
                br_div = 16'd8;
                word   = ~word;
                stop   = ~stop;
            end
            rx_in = d[nb-1-k];
            repeat (per) tick();
        end
        for (int j = 0; j < ns; j++) begin
            if (j == 0) begin
                br_div = br0;
                word   = w0;
                stop   = s0;
            end
            rx_in = stop_val;
            repeat (per) tick();
        end
        rx_in = 1'b1;
    endtask

    // Synchronized line as seen c cycles in: the raw line S cycles earlier, or idle-high
    // if a reset landed inside that window.
    function automatic bit rxs_at(input int c);
        if (c - S < 0) return 1'b1;
        for (int k = c - S; k <= c - 1; k++) begin
            if (rst_a[k]) return 1'b1;
        end
        return line_a[c-S];
    endfunction

    task automatic run_model(input int n);
        int  t;
        bit  armed;
        t     = 1;
        armed = 1'b0;
        while (t < n) begin
            if (rst_a[t]) begin
                armed = 1'b0;
                t++;
            end else if (armed && !rxs_at(t)) begin
                int t0, b, h, nb, ns, ts, ab, val;
                bit fs, err;
                t0 = t;
                b  = int'(br_a[t0]);
                h  = b / 2;
                nb = word_a[t0] ? 9 : 8;
                ns = stop_a[t0] ? 2 : 1;
                fs = rxs_at(t0 + h);
                ts = fs ? t0 + h : t0 + h + (nb + ns) * b;
                if (ts + 1 >= n) break;
                ab = -1;
                for (int c = t0 + 1; c <= ts; c++) begin
                    if (rst_a[c]) begin
                        ab = c;
                        break;
                    end
                end
                for (int c = t0 + 1; c <= ((ab >= 0) ? ab : ts); c++) eb_a[c] = 1'b1;
                if (ab >= 0) begin
                    t = ab;
                end else if (fs) begin
                    t = ts + 1;
                end else begin
                    val = 0;
                    for (int k = 0; k < nb; k++) val = val * 2 + int'(rxs_at(t0 + h + (k + 1) * b));
                    err = 1'b0;
                    for (int j = 0; j < ns; j++) begin
                        if (!rxs_at(t0 + h + (nb + 1 + j) * b)) err = 1'b1;
                    end
                    ev_a[ts+1] = 1'b1;
                    ed_a[ts+1] = val[8:0];
                    ee_a[ts+1] = err;
                    if (err) armed = 1'b0;
                    t = ts + 1;
                end
            end else begin
                if (rxs_at(t)) armed = 1'b1;
                t++;
            end
        end
    endtask

    function automatic int count_valid(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (ov_a[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_busy(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (ob_a[c] === 1'b1) n++;
        return n;
    endfunction

    int f1, f2, f3, f4, h4, f5, f6a, r6, f6, ncyc;

    initial begin
        logic [7:0] ab;
        logic [8:0] cur_d;
        bit         cur_e;
        int         t02, ts2;

        repeat (4) tick();
        rst = 1'b0;
        idle(20);

        // 8N1 0xA5 at br_div=16
        f1 = cyc;
        send_frame(9'h0A5, 8, 1, 16, 1'b1, -1);
        idle(32);

        // 9-bit, two stop bits at br_div=10
        br_div = 16'd10; word = 1'b1; stop = 1'b1;
        idle(20);
        f2 = cyc;
        send_frame(9'h1C3, 9, 2, 10, 1'b1, -1);
        idle(30);

        // 3-cycle glitch
        br_div = 16'd16; word = 1'b0; stop = 1'b0;
        idle(20);
        f3 = cyc;
        rx_in = 1'b0;
        repeat (3) tick();
        idle(40);

        // Bad stop bit followed by a long break
        f4 = cyc;
        send_frame(9'h03C, 8, 1, 16, 1'b0, -1);
        rx_in = 1'b0;
        repeat (40 * 16) tick();
        h4 = cyc;
        idle(64);

        // Back-to-back frames with br_div disturbed mid-frame
        f5 = cyc;
        send_frame(9'h055, 8, 1, 16, 1'b1, 3);
        send_frame(9'h0FF, 8, 1, 16, 1'b1, 2);
        idle(40);

        // Reset during data bit 4, then a clean frame
        f6a = cyc;
        ab  = 8'h5A;
        rx_in = 1'b0;
        repeat (16) tick();
        for (int k = 0; k < 4; k++) begin
            rx_in = ab[7-k];
            repeat (16) tick();
        end
        rx_in = ab[3];
        repeat (8) tick();
        rst   = 1'b1;
        rx_in = 1'b1;
        r6    = cyc;
        tick();
        rst = 1'b0;
        idle(48);
        f6 = cyc;
        send_frame(9'h081, 8, 1, 16, 1'b1, -1);
        idle(40);

        // Random frames
        for (int i = 0; i < 14; i++) begin
            int per, nb, ns, chg;
            bit sv;
            per    = $urandom_range(4, 20);
            br_div = 16'(per);
            word   = 1'($urandom_range(0, 1));
            stop   = 1'($urandom_range(0, 1));
            nb     = word ? 9 : 8;
            ns     = stop ? 2 : 1;
            sv     = ($urandom_range(0, 5) != 0);
            chg    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
            idle(per);
            send_frame(9'($urandom), nb, ns, per, sv, chg);
            idle(per * int'($urandom_range(1, 3)));
        end
        idle(300);
        @(negedge clk);
        ncyc = cyc;

        // Directed checks against fixed expectations
        check_eq("a5_count", count_valid(f1, f1 + L + 20), 1);
        check_eq("a5_valid_at_latency", ov_a[f1+L], 1'b1);
        check_eq("a5_data", od_a[f1+L], 9'h0A5);
        check_eq("a5_err", oe_a[f1+L], 1'b0);

        t02 = f2 + S;
        ts2 = t02 + 5 + 11 * 10;
        check_eq("1c3_busy_cycles", count_busy(t02 + 1, ts2), ts2 - t02);
        check_eq("1c3_valid", ov_a[ts2+1], 1'b1);
        check_eq("1c3_busy_after", ob_a[ts2+1], 1'b0);
        check_eq("1c3_data", od_a[ts2+1], 9'h1C3);
        check_eq("1c3_err", oe_a[ts2+1], 1'b0);

        check_eq("glitch_no_valid", count_valid(f3, f3 + 40), 0);
        check_eq("glitch_busy_cycles", count_busy(f3, f3 + 40), 8);
        check_eq("glitch_busy_drop", ob_a[f3+S+8+1], 1'b0);

        check_eq("break_count", count_valid(f4, h4 + S), 1);
        check_eq("break_valid", ov_a[f4+L], 1'b1);
        check_eq("break_data", od_a[f4+L], 9'h03C);
        check_eq("break_err", oe_a[f4+L], 1'b1);

        check_eq("b2b_count", count_valid(f5, f5 + 160 + L + 10), 2);
        check_eq("b2b_first", {ov_a[f5+L], od_a[f5+L]}, {1'b1, 9'h055});
        check_eq("b2b_second", {ov_a[f5+160+L], od_a[f5+160+L]}, {1'b1, 9'h0FF});

        check_eq("rst_outputs", {ov_a[r6+1], ob_a[r6+1], oe_a[r6+1], od_a[r6+1]}, 12'h000);
        check_eq("rst_no_valid", count_valid(f6a, f6 - 1), 0);
        check_eq("after_rst_frame", {ov_a[f6+L], oe_a[f6+L], od_a[f6+L]}, {2'b10, 9'h081});

        // Cycle-by-cycle comparison with the model
        run_model(ncyc);
        cur_d = 9'd0;
        cur_e = 1'b0;
        for (int c = 1; c < ncyc; c++) begin
            if (rst_a[c-1]) begin
                cur_d = 9'd0;
                cur_e = 1'b0;
            end
            if (ev_a[c]) begin
                cur_d = ed_a[c];
                cur_e = ee_a[c];
            end
            check_eq($sformatf("cyc%0d_vbed", c), {ov_a[c], ob_a[c], oe_a[c], od_a[c]},
                     {ev_a[c], eb_a[c], cur_e, cur_d});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
